i_encoder_writer: RTL and testbench
===================================

# i_encoder_writer

I-type instruction encoder and program-memory writer for the MIPS core's bring-up and test path. It accepts one-hot I-type operation flags plus rs/rt/imm fields over a valid/ready handshake. It packs them into 32-bit MIPS instruction words and writes them sequentially into instruction memory through a write port with backpressure. It is the encoding counterpart of the I-type opcode decoder in the controller.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written.
- `DEPTH`, default 256: maximum number of words written before `full`.
- `clk`, input, 1: clock. All logic is rising-edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `clear`, input, 1: synchronous restart. Rewinds to `BASE_ADDR` and clears the count and the error flags.
- `in_valid`, input, 1: the instruction request is valid.
- `in_ready`, output, 1: the block can accept a request.
- `op`, input, 16: one-hot operation select. Bit order from 0 to 15: addi, addiu, andi, xori, ori, beq, bne, blez, bgtz, bgez, lw, sw, lb, sb, slti, lui.
- `rs`, input, 5: source register field.
- `rt`, input, 5: target register field.
- `imm`, input, 16: immediate or offset field.
- `mem_we`, output, 1: memory write request.
- `mem_addr`, output, 32: byte address of the write. Always word-aligned.
- `mem_wdata`, output, 32: encoded instruction word.
- `mem_ready`, input, 1: memory accepts the write this cycle.
- `full`, output, 1: `DEPTH` words have been written.
- `err`, output, 1: sticky flag. At least one request had an invalid `op`.
- `err_count`, output, 8: number of rejected requests. Saturates at 255.
- `word_count`, output, $clog2(DEPTH+1): number of words successfully written.

## Operation
- Opcode map, 6 bits, per op bit:
  - addi 001000, addiu 001001, andi 001100, xori 001110, ori 001101
  - beq 000100, bne 000101, blez 000110, bgtz 000111, bgez 000001
  - lw 100011, sw 101011, lb 100000, sb 101000
  - slti 001010, lui 001111
- Word layout: `{opcode, rs, rt, imm}` occupying bits [31:26], [25:21], [20:16] and [15:0].
- State machine has three states: IDLE, WRITE and FULL.
- IDLE:
  - `in_ready = !clear`.
  - When `in_valid && in_ready` and `op` is exactly one-hot, the block registers the encoded word and goes to WRITE.
  - When `in_valid && in_ready` and `op` is zero or has more than one bit set, the request is consumed and dropped. `err` is set, `err_count` increments (saturating), and the state stays IDLE.
- WRITE:
  - `mem_we = 1`. `mem_addr` and `mem_wdata` are held stable. `in_ready = 0`.
  - On `mem_ready`, `word_count` increments. The next state is FULL if the new count equals `DEPTH`, otherwise IDLE.
- FULL:
  - `full = 1`, `in_ready = 0`.
  - Only `clear` or `rst` leave this state.
- `mem_addr = BASE_ADDR + 4*word_count`. Address wrap-around cannot occur, because FULL blocks further writes.
- `clear`:
  - Takes effect from any state. The next state is IDLE, and `word_count`, `err` and `err_count` are set to 0.
  - If asserted in WRITE, the pending write is abandoned and `mem_we` is low on the next cycle. The abandoned write is not counted, even if `mem_ready` is high in the same cycle.
  - `clear` together with `in_valid`: clear wins and nothing is accepted.
- Priority: `rst` > `clear` > handshake.

## Timing
- Reset values: state IDLE, `in_ready` 1, `mem_we` 0, `mem_addr` `BASE_ADDR`, `mem_wdata` 0, `full` 0, `err` 0, `err_count` 0, `word_count` 0.
- Request accepted at edge N: `mem_we` is high in cycle N+1 with valid address and data.
- Write completes at the first edge where `mem_we && mem_ready`. `in_ready` is high the following cycle unless the block entered FULL.
- Peak throughput is one word per 2 cycles when `mem_ready` is held high.
- An error rejection takes 1 cycle. `err` and `err_count` update at the accepting edge and `in_ready` stays high.
- `rst` in WRITE drops `mem_we` on the next cycle. No partial state is retained.

## Configuration
- Macro `I_ENC_FIELD_FIX_EN`.
- When defined, the block enforces fixed fields:
  - bgez forces `rt = 5'b00001` (REGIMM sub-code).
  - lui forces `rs = 5'b00000`.
- When undefined, `rs` and `rt` are packed exactly as supplied for every op.

## Test plan
- Reset, then addi with rs=1, rt=2, imm=16'h0005 and `mem_ready` high → `mem_we` is high one cycle later with `mem_addr` 0x0 and `mem_wdata` 0x2022_0005. `word_count` becomes 1.
- lui (`op` 0x8000) with rs=7, rt=3, imm=16'h1234 → `mem_wdata` is 0x3C03_1234 with the macro defined and 0x3CE3_1234 without it. bgez (`op` 0x0200) with rs=4, rt=0, imm=16'hFFFE and the macro defined → `mem_wdata` 0x0481_FFFE.
- Backpressure: `mem_ready` low for 3 cycles, then high → `mem_we` is high for 4 cycles with address and data stable and `in_ready` low throughout. The next word goes to address 0x4.
- Invalid `op` 0x0003, then `op` 0x0000 → no `mem_we`, `err` is 1, `err_count` is 2, `in_ready` stays high, and `word_count` is unchanged.
- With `DEPTH`=4, write 4 valid words → `full` is 1 and `in_ready` is 0, and a 5th request is never accepted. Then `clear` → IDLE, next write goes to `BASE_ADDR`, `word_count` is 0 and `full` is 0.
- `clear` asserted during WRITE with `mem_ready` high in the same cycle → write not counted, `mem_we` low next cycle, `word_count` 0.

Source files
------------

// File: rtl/i_encoder_writer.sv
// i_encoder_writer
//
// I-type instruction encoder and program-memory writer. Accepts one-hot
// I-type operation flags with rs/rt/imm fields over a valid/ready handshake,
// packs them into 32-bit MIPS words {opcode, rs, rt, imm} and writes them
// sequentially from BASE_ADDR through a write port with backpressure.
//
// Parameters:
//   BASE_ADDR  byte address of the first word written
//   DEPTH      number of words written before full
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clear          synchronous restart (rewind address, clear count and errors)
//   in_valid       request valid
//   in_ready       block can accept a request
//   op             one-hot op select (addi .. lui, bits 0..15)
//   rs, rt, imm    instruction fields
//   mem_we         memory write request
//   mem_addr       word-aligned byte address of the write
//   mem_wdata      encoded instruction word
//   mem_ready      memory accepts the write this cycle
//   full           DEPTH words have been written
//   err            sticky: at least one request had an invalid op
//   err_count      rejected requests, saturating at 255
//   word_count     words successfully written
//
// Build option:
//   I_ENC_FIELD_FIX_EN  when defined, bgez forces rt = 1 (REGIMM sub-code)
//                       and lui forces rs = 0.

module i_encoder_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [15:0]                  op,
    input  logic [4:0]                   rs,
    input  logic [4:0]                   rt,
    input  logic [15:0]                  imm,
    output logic                         mem_we,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_ready,
    output logic                         full,
    output logic                         err,
    output logic [7:0]                   err_count,
    output logic [$clog2(DEPTH+1)-1:0]   word_count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DepthW = CW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StFull
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic [7:0]      errcnt_q, errcnt_d;

    // Encoder datapath
    logic [5:0]      opcode;
    logic            op_onehot;
    logic [4:0]      rs_eff;
    logic [4:0]      rt_eff;
    logic [31:0]     enc_word;
    logic [CW-1:0]   count_inc;

    always_comb begin
        opcode = 6'b000000;
        case (op)
            16'h0001: opcode = 6'b001000; // addi
            16'h0002: opcode = 6'b001001; // addiu
            16'h0004: opcode = 6'b001100; // andi
            16'h0008: opcode = 6'b001110; // xori
            16'h0010: opcode = 6'b001101; // ori
            16'h0020: opcode = 6'b000100; // beq
            16'h0040: opcode = 6'b000101; // bne
            16'h0080: opcode = 6'b000110; // blez
            16'h0100: opcode = 6'b000111; // bgtz
            16'h0200: opcode = 6'b000001; // bgez (REGIMM)
            16'h0400: opcode = 6'b100011; // lw
            16'h0800: opcode = 6'b101011; // sw
            16'h1000: opcode = 6'b100000; // lb
            16'h2000: opcode = 6'b101000; // sb
            16'h4000: opcode = 6'b001010; // slti
            16'h8000: opcode = 6'b001111; // lui
            default:  opcode = 6'b000000;
        endcase
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign op_onehot = (op != 16'h0000) && ((op & (op - 16'h0001)) == 16'h0000);

    always_comb begin
        rs_eff = rs;
        rt_eff = rt;
`ifdef I_ENC_FIELD_FIX_EN
        if (op == 16'h0200) begin
            rt_eff = 5'b00001;
        end
        if (op == 16'h8000) begin
            rs_eff = 5'b00000;
        end
`else
        // Fields packed exactly as supplied.
`endif
    end

    assign enc_word  = {opcode, rs_eff, rt_eff, imm};
    assign count_inc = count_q + 1'b1;

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        wdata_d  = wdata_q;
        count_d  = count_q;
        err_d    = err_q;
        errcnt_d = errcnt_q;

        if (clear) begin
            // Abandons any pending write; a same-cycle mem_ready is ignored.
            state_d  = StIdle;
            count_d  = '0;
            err_d    = 1'b0;
            errcnt_d = 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (op_onehot) begin
                            wdata_d = enc_word;
                            state_d = StWrite;
                        end else begin
                            err_d = 1'b1;
                            if (errcnt_q != 8'hFF) begin
                                errcnt_d = errcnt_q + 8'd1;
                            end
                        end
                    end
                end
                StWrite: begin
                    if (mem_ready) begin
                        count_d = count_inc;
                        state_d = (count_inc == DepthW) ? StFull : StIdle;
                    end
                end
                StFull: begin
                    state_d = StFull;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wdata_q  <= 32'h0000_0000;
            count_q  <= '0;
            err_q    <= 1'b0;
            errcnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            wdata_q  <= wdata_d;
            count_q  <= count_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

    // Outputs
    assign in_ready   = (state_q == StIdle) && !clear;
    assign mem_we     = (state_q == StWrite);
    assign full       = (state_q == StFull);
    // Count is frozen while in WRITE, so the address is stable for the whole write.
    assign mem_addr   = BASE_ADDR + (32'(count_q) << 2);
    assign mem_wdata  = wdata_q;
    assign err        = err_q;
    assign err_count  = errcnt_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_i_encoder_writer.sv
module tb_i_encoder_writer;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            clear;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [15:0]     imm;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic            mem_ready;
    logic            full;
    logic            err;
    logic [7:0]      err_count;
    logic [CW-1:0]   word_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    i_encoder_writer #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .rs         (rs),
        .rt         (rt),
        .imm        (imm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .full       (full),
        .err        (err),
        .err_count  (err_count),
        .word_count (word_count)
    );

    // Opcode per op bit position 0..15.
    logic [5:0] opc_tab [0:15] = '{
        6'b001000, 6'b001001, 6'b001100, 6'b001110, 6'b001101,
        6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001,
        6'b100011, 6'b101011, 6'b100000, 6'b101000,
        6'b001010, 6'b001111
    };

    // Reference model: pending word, count of completed writes, error tally.
    logic        m_pending;
    logic [31:0] m_word;
    int          m_count;
    logic        m_err;
    int          m_errcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_encode(input logic [15:0] o, input logic [4:0] s,
                                                 input logic [4:0] t, input logic [15:0] i);
        int idx = 0;
        logic [4:0] s2 = s;
        logic [4:0] t2 = t;
        for (int k = 0; k < 16; k++) begin
            if (o[k]) idx = k;
        end
`ifdef I_ENC_FIELD_FIX_EN
        if (idx == 9) t2 = 5'd1;
        if (idx == 15) s2 = 5'd0;
`endif
        return {opc_tab[idx], s2, t2, i};
    endfunction

    task automatic model_reset();
        m_pending = 1'b0;
        m_word    = 32'h0;
        m_count   = 0;
        m_err     = 1'b0;
        m_errcnt  = 0;
    endtask

    task automatic check_outputs();
        check("in_ready", 32'(in_ready),
              32'(!m_pending && (m_count != DEPTH) && !clear));
        check("mem_we", 32'(mem_we), 32'(m_pending));
        check("mem_addr", mem_addr, BASE + 32'(4 * m_count));
        check("mem_wdata", mem_wdata, m_word);
        check("full", 32'(full), 32'(m_count == DEPTH));
        check("err", 32'(err), 32'(m_err));
        check("err_count", 32'(err_count), 32'(m_errcnt));
        check("word_count", 32'(word_count), 32'(m_count));
    endtask

    // One clock cycle: apply inputs, check outputs, advance model across the edge.
    task automatic drive(input logic v, input logic [15:0] o, input logic [4:0] s,
                         input logic [4:0] t, input logic [15:0] i, input logic mr,
                         input logic cl);
        in_valid  = v;
        op        = o;
        rs        = s;
        rt        = t;
        imm       = i;
        mem_ready = mr;
        clear     = cl;
        #1;
        check_outputs();
        if (cl) begin
            m_pending = 1'b0;
            m_count   = 0;
            m_err     = 1'b0;
            m_errcnt  = 0;
        end else if (m_pending) begin
            if (mr) begin
                m_pending = 1'b0;
                m_count++;
            end
        end else if (m_count < DEPTH && v) begin
            if ($countones(o) == 1) begin
                m_word    = model_encode(o, s, t, i);
                m_pending = 1'b1;
            end else begin
                m_err    = 1'b1;
                m_errcnt = (m_errcnt < 255) ? m_errcnt + 1 : 255;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic mr);
        drive(1'b0, 16'h0, 5'd0, 5'd0, 16'h0, mr, 1'b0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        op        = 16'h0;
        rs        = 5'd0;
        rt        = 5'd0;
        imm       = 16'h0;
        mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [15:0] r_op;
        do_reset();

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);

        // addi rs=1 rt=2 imm=5
        drive(1'b1, 16'h0001, 5'd1, 5'd2, 16'h0005, 1'b1, 1'b0);
        check("addi_we", 32'(mem_we), 32'd1);
        check("addi_addr", mem_addr, BASE);
        check("addi_word", mem_wdata, 32'h2022_0005);
        idle(1'b1);
        check("addi_count", 32'(word_count), 32'd1);

        // lui rs=7 rt=3 imm=1234
        drive(1'b1, 16'h8000, 5'd7, 5'd3, 16'h1234, 1'b1, 1'b0);
`ifdef I_ENC_FIELD_FIX_EN
        check("lui_word", mem_wdata, 32'h3C03_1234);
`else
        check("lui_word", mem_wdata, 32'h3CE3_1234);
`endif
        idle(1'b1);

        // bgez rs=4 rt=0 imm=FFFE, with backpressure for 3 cycles
        drive(1'b1, 16'h0200, 5'd4, 5'd0, 16'hFFFE, 1'b0, 1'b0);
`ifdef I_ENC_FIELD_FIX_EN
        check("bgez_word", mem_wdata, 32'h0481_FFFE);
`else
        check("bgez_word", mem_wdata, 32'h0480_FFFE);
`endif
        check("bp_addr", mem_addr, BASE + 32'h8);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        check("bp_we_held", 32'(mem_we), 32'd1);
        check("bp_ready_low", 32'(in_ready), 32'd0);
        idle(1'b1);
        check("bp_done_we", 32'(mem_we), 32'd0);
        check("bp_count", 32'(word_count), 32'd3);

        // Invalid ops
        drive(1'b1, 16'h0003, 5'd1, 5'd1, 16'h1, 1'b1, 1'b0);
        drive(1'b1, 16'h0000, 5'd1, 5'd1, 16'h1, 1'b1, 1'b0);
        check("inv_err", 32'(err), 32'd1);
        check("inv_err_count", 32'(err_count), 32'd2);
        check("inv_ready", 32'(in_ready), 32'd1);
        check("inv_count", 32'(word_count), 32'd3);

        // Fill to DEPTH, then requests must be refused
        drive(1'b1, 16'h0400, 5'd9, 5'd10, 16'h0040, 1'b1, 1'b0);
        idle(1'b1);
        check("full_flag", 32'(full), 32'd1);
        check("full_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'h0001, 5'd3, 5'd3, 16'h3, 1'b1, 1'b0);
        end
        check("full_no_we", 32'(mem_we), 32'd0);
        check("full_count", 32'(word_count), 32'd4);
        drive(1'b0, 16'h0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b1);
        check("clr_full", 32'(full), 32'd0);
        check("clr_count", 32'(word_count), 32'd0);
        check("clr_err", 32'(err), 32'd0);
        drive(1'b1, 16'h0010, 5'd2, 5'd5, 16'hABCD, 1'b0, 1'b0);
        check("clr_addr", mem_addr, BASE);

        // Clear during WRITE with mem_ready high: write dropped
        drive(1'b1, 16'h0001, 5'd1, 5'd1, 16'h1, 1'b1, 1'b1);
        check("cw_we", 32'(mem_we), 32'd0);
        check("cw_count", 32'(word_count), 32'd0);

        // err_count saturation
        for (int k = 0; k < 260; k++) begin
            drive(1'b1, 16'h0003, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0);
        end
        check("sat_err_count", 32'(err_count), 32'd255);
        drive(1'b0, 16'h0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b1);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            if ($urandom_range(0, 9) < 7) begin
                r_op = 16'h0001 << $urandom_range(0, 15);
            end else begin
                r_op = 16'($urandom);
            end
            drive(1'($urandom_range(0, 3) != 0), r_op, 5'($urandom), 5'($urandom),
                  16'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 39) == 0));
        end
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
